// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-core arbiter.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Result constants are wide enough for any operand width up to 64 and are truncated at use.
  localparam int unsigned MAX_W = 64;
  localparam logic [MAX_W-1:0] DIV0_RESULT    = '1;
  localparam logic [MAX_W-1:0] TIMEOUT_RESULT = '0;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after last_winner+1.
module rr_picker
  import div_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic             o_grant_valid_c,
  output logic [ID_W-1:0]  o_grant_id_c
);

  logic [ID_W-1:0]    w_start;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_pos;
  logic [ID_W:0]      w_sum;

  // Rotate so the highest-priority requester sits at bit 0, pick, then rotate the index back.
  always_comb begin
    w_start = (i_last == ID_W'(N_REQ - 1)) ? '0 : ID_W'(i_last + 1'b1);
    w_dbl   = {i_req, i_req} >> w_start;
    w_rot   = w_dbl[N_REQ-1:0];
    w_pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = ID_W'(i);
    end
    w_sum           = {1'b0, w_start} + {1'b0, w_pos};
    o_grant_valid_c = |i_req;
    o_grant_id_c    = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                                                 : ID_W'(w_sum);
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one divider core between N_REQ requesters,
// with divide-by-zero interception and a RUN-cycle timeout.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_req_dv,
  input  logic [N_REQ*W-1:0] i_req_dr,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_rsp_valid,
  output logic [W-1:0]       o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_core_start,
  output logic [W-1:0]       o_core_dv,
  output logic [W-1:0]       o_core_dr,
  input  logic               i_core_done,
  input  logic [W-1:0]       i_core_r,
  output logic               o_busy
);

  localparam int unsigned ID_W  = id_width(N_REQ);
  localparam int unsigned CNT_W = id_width(TIMEOUT);

  state_t             r_state;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [W-1:0]       r_rsp_data;
  logic               r_rsp_err;
  logic               r_core_start;
  logic [W-1:0]       r_core_dv;
  logic [W-1:0]       r_core_dr;
  logic               r_busy;

  logic               w_grant_valid;
  logic [ID_W-1:0]    w_grant_id;
  logic [W-1:0]       w_sel_dv;
  logic [W-1:0]       w_sel_dr;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req           (i_req),
    .i_last          (r_last),
    .o_grant_valid_c (w_grant_valid),
    .o_grant_id_c    (w_grant_id)
  );

  always_comb begin
    w_sel_dv = i_req_dv[w_grant_id*W +: W];
    w_sel_dr = i_req_dr[w_grant_id*W +: W];
  end

  // Sequencer: IDLE arbitrates, RUN drives the core, RESP is the one-cycle result slot.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_last       <= ID_W'(N_REQ - 1);
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_core_start <= 1'b0;
      r_core_dv    <= '0;
      r_core_dr    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_id      <= w_grant_id;
            r_last    <= w_grant_id;
            r_gnt     <= N_REQ'(1) << w_grant_id;
            r_core_dv <= w_sel_dv;
            r_core_dr <= w_sel_dr;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            if (w_sel_dr == '0) begin
              // Divide-by-zero answers immediately; the core is never started.
              r_rsp_valid <= N_REQ'(1) << w_grant_id;
              r_rsp_data  <= W'(DIV0_RESULT);
              r_rsp_err   <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_core_start <= 1'b1;
              r_state      <= RUN;
            end
          end
        end
        RUN: begin
          if (i_core_done) begin
            r_rsp_valid  <= N_REQ'(1) << r_id;
            r_rsp_data   <= i_core_r;
            r_rsp_err    <= 1'b0;
            r_core_start <= 1'b0;
            r_state      <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_valid  <= N_REQ'(1) << r_id;
            r_rsp_data   <= W'(TIMEOUT_RESULT);
            r_rsp_err    <= 1'b1;
            r_core_start <= 1'b0;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_core_start <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_err    = r_rsp_err;
  assign o_core_start = r_core_start;
  assign o_core_dv    = r_core_dv;
  assign o_core_dr    = r_core_dr;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider core of programmable latency.
module tb_div_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_dv;
  logic [N*W-1:0] req_dr;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           core_start;
  logic [W-1:0]   core_dv;
  logic [W-1:0]   core_dr;
  logic           core_done;
  logic [W-1:0]   core_r;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int delay  = 5;
  int start_cnt = 0;

  div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_req        (req),
    .i_req_dv     (req_dv),
    .i_req_dr     (req_dr),
    .o_gnt        (gnt),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_rsp_err    (rsp_err),
    .o_core_start (core_start),
    .o_core_dv    (core_dv),
    .o_core_dr    (core_dr),
    .i_core_done  (core_done),
    .i_core_r     (core_r),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Core model: done rises once START has been high for 'delay' clock edges.
  always @(posedge clk) begin
    if (core_start) start_cnt <= start_cnt + 1;
    else            start_cnt <= 0;
  end
  assign core_done = core_start && (start_cnt >= delay);
  assign core_r    = (core_dr != '0) ? core_dv / core_dr : '1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int dv, input int dr);
    req_dv[i*W +: W] = W'(dv);
    req_dr[i*W +: W] = W'(dr);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  logic [N-1:0] order [6];
  int           gcyc  [6];
  int           exp_order [6] = '{1, 2, 4, 8, 1, 2};
  int           n_start;
  int           n_gnt;
  int           cyc;

  initial begin
    rst_n = 1'b0; req = '0; req_dv = '0; req_dr = '0;
    for (int i = 0; i < 6; i++) begin order[i] = '0; gcyc[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_gnt",   32'(gnt), 0);
    chk("rst_rsp_v", 32'(rsp_valid), 0);
    chk("rst_data",  32'(rsp_data), 0);
    chk("rst_err",   32'(rsp_err), 0);
    chk("rst_start", 32'(core_start), 0);
    chk("rst_dv",    32'(core_dv), 0);
    chk("rst_dr",    32'(core_dr), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 5-cycle core latency.
    delay = 5; req = 4'b0001; set_op(0, 100, 7);
    @(negedge clk);
    chk("s1_gnt",   32'(gnt), 1);
    chk("s1_start", 32'(core_start), 1);
    chk("s1_busy",  32'(busy), 1);
    chk("s1_dv",    32'(core_dv), 100);
    chk("s1_dr",    32'(core_dr), 7);
    req = '0; n_start = 1;
    repeat (5) begin
      @(negedge clk);
      if (core_start) n_start++;
      chk("s1_rsp_early", 32'(rsp_valid), 0);
    end
    @(negedge clk);
    if (core_start) n_start++;
    chk("s1_rsp_v",     32'(rsp_valid), 1);
    chk("s1_rsp_data",  32'(rsp_data), 14);
    chk("s1_rsp_err",   32'(rsp_err), 0);
    chk("s1_start_len", 32'(n_start), 6);
    @(negedge clk);
    chk("s1_rsp_once",  32'(rsp_valid), 0);
    chk("s1_idle",      32'(busy), 0);

    // Fairness from reset, all requesters held high.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    delay = 2; req = 4'hF;
    for (int i = 0; i < 4; i++) set_op(i, 10 * (i + 1), 1);
    n_gnt = 0; cyc = 0;
    while (n_gnt < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        order[n_gnt] = gnt;
        gcyc[n_gnt]  = cyc;
        n_gnt++;
      end
    end
    req = '0;
    chk("fair_count", 32'(n_gnt), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    chk("fair_gap", 32'(gcyc[1] - gcyc[0]), 5);
    wait_idle("fair_idle");

    // Divide-by-zero: grant and response coincide, core untouched.
    req = 4'b0100; set_op(2, 5, 0);
    @(negedge clk);
    chk("dz_gnt",   32'(gnt), 4);
    chk("dz_rsp_v", 32'(rsp_valid), 4);
    chk("dz_data",  32'(rsp_data), 32'hFFFF);
    chk("dz_err",   32'(rsp_err), 1);
    chk("dz_start", 32'(core_start), 0);
    req = '0;
    @(negedge clk);
    chk("dz_rsp_once", 32'(rsp_valid), 0);
    chk("dz_start2",   32'(core_start), 0);
    chk("dz_idle",     32'(busy), 0);

    // Timeout: core never answers.
    delay = 1000; req = 4'b0010; set_op(1, 9, 3);
    @(negedge clk);
    chk("to_gnt", 32'(gnt), 2);
    req = '0;
    repeat (63) @(negedge clk);
    chk("to_rsp_early", 32'(rsp_valid), 0);
    chk("to_start_run", 32'(core_start), 1);
    @(negedge clk);
    chk("to_rsp_v",  32'(rsp_valid), 2);
    chk("to_data",   32'(rsp_data), 0);
    chk("to_err",    32'(rsp_err), 1);
    chk("to_start",  32'(core_start), 0);
    @(negedge clk);
    chk("to_start2", 32'(core_start), 0);
    chk("to_idle",   32'(busy), 0);

    // Done arrives on the last allowed RUN cycle: done wins over timeout.
    delay = 63; req = 4'b1000; set_op(3, 200, 10);
    @(negedge clk);
    chk("edge_gnt", 32'(gnt), 8);
    req = '0;
    repeat (63) @(negedge clk);
    chk("edge_rsp_early", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("edge_rsp_v", 32'(rsp_valid), 8);
    chk("edge_data",  32'(rsp_data), 20);
    chk("edge_err",   32'(rsp_err), 0);
    @(negedge clk);
    chk("edge_idle",  32'(busy), 0);

    // Reset three cycles into RUN with the request still held.
    delay = 1000; req = 4'b0001; set_op(0, 50, 5);
    @(negedge clk);
    chk("mr_gnt", 32'(gnt), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_start_async", 32'(core_start), 0);
    chk("mr_busy_async",  32'(busy), 0);
    repeat (2) begin
      @(negedge clk);
      chk("mr_no_rsp", 32'(rsp_valid), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_regnt",   32'(gnt), 1);
    chk("mr_restart", 32'(core_start), 1);
    chk("mr_no_rsp2", 32'(rsp_valid), 0);
    req = '0;
    wait_idle("mr_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
